spike_aer_encoder: RTL and testbench
====================================

Name: spike_aer_encoder

Overview:
- Downstream consumer of the LIF neuron array's per-neuron spike lines.
- Converts parallel spikes into a serial stream of address-event (AER) words {neuron index, timestamp}.
- Buffers events in a small FIFO behind a valid/ready interface, so an off-chip or serializer stage can drain them at its own rate.
- Counts spikes lost to backpressure.

Parameters:
N_NEURONS, 5, number of spike inputs
ADDR_W, 3, width of neuron index (ceil(log2(N_NEURONS)))
TS_W, 8, timestamp width
FIFO_DEPTH, 8, event FIFO entries (power of two)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
en  input  1  when low, new spikes ignored; draining continues
spike_in  input  N_NEURONS  one bit per neuron, sampled every edge
ev_valid  output  1  head event available
ev_ready  input  1  consumer accepts head event
ev_addr  output  ADDR_W  neuron index of head event
ev_ts  output  TS_W  timestamp of head event
fifo_count  output  log2(FIFO_DEPTH)+1  entries currently stored
drop_cnt  output  8  saturating count of lost spikes

Behaviour:
- Reset (rst high at an edge): ts_cnt=0, pending=0, all pend_ts=0, FIFO empty.
  - Outputs: ev_valid=0, ev_addr=0, ev_ts=0, fifo_count=0, drop_cnt=0.
  - Reset mid-operation discards all queued and pending events; it has priority over every other action.
- Timestamp: ts_cnt increments every non-reset edge and wraps from 2^TS_W-1 to 0. It ignores en.
- Pending stage, one bit pending[i] and one register pend_ts[i] per neuron:
  - Arming: at an edge with en=1 and spike_in[i]=1:
    - if pending[i]=0, or pending[i] is being cleared by enqueue at this same edge: pending[i]<=1, pend_ts[i]<=current ts_cnt. No drop.
    - else (pending[i]=1 and not cleared this edge): the spike is lost and counted as a drop.
  - drop_cnt adds the number of dropped spikes at that edge and saturates at 255.
- Enqueue:
  - Condition: at each edge, if any pending bit is set and (FIFO not full, or FIFO full and a pop occurs this edge).
  - Selection: the lowest-index pending i is chosen (fixed priority; starvation of higher indices under sustained load is accepted).
  - Action: {i, pend_ts[i]} is written to the FIFO and pending[i] is cleared.
  - At most one enqueue per edge.
- FIFO:
  - Show-ahead: ev_addr/ev_ts always reflect the head entry; they are 0 when empty.
  - ev_valid = (fifo_count != 0).
  - Pop occurs on an edge with ev_valid & ev_ready.
  - Simultaneous push and pop leaves fifo_count unchanged, including when full or holding one entry.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head outputs are stable while ev_valid=1 and ev_ready=0.
- Latency:
  - spike_in high in cycle 0 → pending set at end of cycle 0 → pushed at end of cycle 1 → ev_valid=1 in cycle 2.
  - The event's ts equals ts_cnt during cycle 0.
- en low does not clear pending bits; they still enqueue.

Test Plan:
1. Reset: assert rst 2 cycles with spike_in=5'b11111 → ev_valid=0, fifo_count=0, drop_cnt=0. In the first cycle after release, ts_cnt=0.
2. Single spike: ev_ready=1, spike_in=5'b00100 for the one cycle where ts_cnt=5 → two cycles later ev_valid=1, ev_addr=2, ev_ts=5 for one cycle, then ev_valid=0.
3. Simultaneous spikes: ev_ready=1, spike_in=5'b10101 at ts_cnt=10 → events (0,10), (2,10), (4,10) on consecutive cycles starting 2 cycles later; drop_cnt=0.
4. Backpressure and starvation: ev_ready=0, spike_in=5'b11111 for 20 edges starting ts_cnt=0.
   - Required: fifo_count=8, and all entries have addr 0 with ts 0..7.
   - Required: drop_cnt=87 (4 per edge for edges 1-8, 5 per edge for edges 9-19).
5. Full with simultaneous pop: FIFO full, pending[3]=1, ev_ready=1 for one edge → head popped, (3, pend_ts[3]) pushed, fifo_count stays 8, pending[3]=0.
6. Wrap, en and mid-run reset:
   - spike at ts_cnt=255 → ev_ts=255; spike at the next ts_cnt, 0 → ev_ts=0.
   - en=0 with spike_in=5'b11111 → no new events.
   - rst while fifo_count=4 → fifo_count=0 and ev_valid=0 the next cycle.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: parallel spike lines -> serial AER words {neuron, timestamp}.
// One pending slot per neuron holds the spike until it wins the single enqueue
// port; a show-ahead FIFO presents events behind a valid/ready handshake.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 5,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_NEURONS-1:0]          spike_in,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [ADDR_W-1:0]             ev_addr,
    output logic [TS_W-1:0]               ev_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TS_W-1:0]      ts_cnt;
    logic [N_NEURONS-1:0] pending;
    logic [TS_W-1:0]      pend_ts [N_NEURONS];
    logic [ADDR_W-1:0]    mem_addr [FIFO_DEPTH];
    logic [TS_W-1:0]      mem_ts [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 full, pop, push;
    logic [ADDR_W-1:0]    sel;
    logic [N_NEURONS-1:0] clr, arm, drop;
    logic [7:0]           ndrop;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_next;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = (|pending) & (~full | pop);
    assign arm      = en ? spike_in : '0;

    // Lowest-index pending neuron wins the enqueue port.
    always_comb begin
        sel = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--)
            if (pending[i]) sel = ADDR_W'(i);
    end

    // Slot being drained this edge can be re-armed without losing the new spike.
    always_comb begin
        clr   = '0;
        ndrop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            clr[i]  = push && (sel == ADDR_W'(i));
            drop[i] = arm[i] & pending[i] & ~clr[i];
            ndrop   = ndrop + 8'(drop[i]);
        end
        drop_sum  = {1'b0, drop_cnt} + {1'b0, ndrop};
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Free-running timestamp, drop counter and per-neuron pending slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt   <= '0;
            pending  <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < N_NEURONS; i++) pend_ts[i] <= '0;
        end else begin
            ts_cnt   <= ts_cnt + TS_W'(1);
            pending  <= (pending & ~clr) | arm;
            drop_cnt <= drop_next;
            for (int i = 0; i < N_NEURONS; i++)
                if (arm[i] && (!pending[i] || clr[i])) pend_ts[i] <= ts_cnt;
        end
    end

    // Event FIFO storage and pointers; count tracks occupancy directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_ts[i]   <= '0;
            end
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= sel;
                mem_ts[wr_ptr]   <= pend_ts[sel];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign fifo_count = count;
    assign ev_addr    = ev_valid ? mem_addr[rd_ptr] : '0;
    assign ev_ts      = ev_valid ? mem_ts[rd_ptr]   : '0;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with hand-computed expectations.
module tb_spike_aer_encoder;
    logic       clk = 1'b0;
    logic       rst, en, ev_ready;
    logic [4:0] spike_in;
    logic       ev_valid;
    logic [2:0] ev_addr;
    logic [7:0] ev_ts;
    logic [3:0] fifo_count;
    logic [7:0] drop_cnt;

    int checks = 0;
    int passed = 0;

    spike_aer_encoder #(.N_NEURONS(5), .ADDR_W(3), .TS_W(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [2:0] a,
                            input logic [7:0] t);
        chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
        chk({tag, ".addr"},  32'(ev_addr),  32'(a));
        chk({tag, ".ts"},    32'(ev_ts),    32'(t));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with spikes asserted
        rst = 1'b1; en = 1'b1; ev_ready = 1'b0; spike_in = 5'b11111;
        tick(); tick();
        chk_head("rst", 1'b0, 3'd0, 8'd0);
        chk("rst.count", 32'(fifo_count), 0);
        chk("rst.drop",  32'(drop_cnt),   0);
        // first cycle after release has ts 0: spike neuron 0 here
        rst = 1'b0; ev_ready = 1'b1; spike_in = 5'b00001;
        tick(); spike_in = 5'b00000;             // cycle 1
        tick();                                  // cycle 2
        chk_head("ts0", 1'b1, 3'd0, 8'd0);
        tick();                                  // cycle 3
        chk_head("ts0.gone", 1'b0, 3'd0, 8'd0);

        // 2. single spike at ts 5
        tick(); tick();                          // cycle 5
        spike_in = 5'b00100;
        tick(); spike_in = 5'b00000;             // cycle 6
        chk_head("single.lat1", 1'b0, 3'd0, 8'd0);
        tick();                                  // cycle 7
        chk_head("single", 1'b1, 3'd2, 8'd5);
        chk("single.count", 32'(fifo_count), 1);
        tick();                                  // cycle 8
        chk_head("single.gone", 1'b0, 3'd0, 8'd0);

        // 3. simultaneous spikes at ts 10
        tick(); tick();                          // cycle 10
        spike_in = 5'b10101;
        tick(); spike_in = 5'b00000;             // cycle 11
        tick(); chk_head("sim0", 1'b1, 3'd0, 8'd10);
        tick(); chk_head("sim1", 1'b1, 3'd2, 8'd10);
        chk("sim1.count", 32'(fifo_count), 1);
        tick(); chk_head("sim2", 1'b1, 3'd4, 8'd10);
        tick(); chk_head("sim.done", 1'b0, 3'd0, 8'd0);
        chk("sim.drop", 32'(drop_cnt), 0);

        // 4. backpressure: 20 edges of all-ones from ts 0
        rst = 1'b1; tick(); rst = 1'b0;
        ev_ready = 1'b0; spike_in = 5'b11111;
        repeat (20) tick();
        spike_in = 5'b00000;
        chk("bp.count", 32'(fifo_count), 8);
        chk("bp.drop",  32'(drop_cnt),   87);
        chk_head("bp.head", 1'b1, 3'd0, 8'd0);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk_head("bp.head2", 1'b1, 3'd0, 8'd1);
        chk("bp.count2", 32'(fifo_count), 8);
        spike_in = 5'b11111;
        repeat (40) tick();
        spike_in = 5'b00000;
        chk("bp.sat", 32'(drop_cnt), 255);

        // 5. full FIFO with only pending[3], one-edge pop
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2.drop", 32'(drop_cnt), 0);
        ev_ready = 1'b0; spike_in = 5'b00001;
        repeat (8) tick();                       // cycle 8, count 7
        chk("full.count7", 32'(fifo_count), 7);
        spike_in = 5'b01000;
        tick(); spike_in = 5'b00000;             // cycle 9
        chk("full.count8", 32'(fifo_count), 8);
        chk_head("full.head", 1'b1, 3'd0, 8'd0);
        tick();
        chk("full.hold", 32'(fifo_count), 8);
        chk_head("full.stable", 1'b1, 3'd0, 8'd0);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk("full.pushpop", 32'(fifo_count), 8);
        chk_head("full.head2", 1'b1, 3'd0, 8'd1);
        ev_ready = 1'b1;
        repeat (7) tick();
        chk_head("full.n3", 1'b1, 3'd3, 8'd8);
        chk("full.last", 32'(fifo_count), 1);
        tick();
        chk("full.empty", 32'(fifo_count), 0);
        chk("full.drop", 32'(drop_cnt), 0);

        // 6a. timestamp wrap
        rst = 1'b1; tick(); rst = 1'b0;
        ev_ready = 1'b1;
        repeat (255) tick();                     // ts 255
        spike_in = 5'b00010;
        tick(); spike_in = 5'b01000;             // ts 0
        tick(); spike_in = 5'b00000;             // ts 1
        chk_head("wrap255", 1'b1, 3'd1, 8'd255);
        tick();
        chk_head("wrap0", 1'b1, 3'd3, 8'd0);
        tick();
        chk_head("wrap.done", 1'b0, 3'd0, 8'd0);

        // 6b. en low blocks new spikes
        en = 1'b0; spike_in = 5'b11111;
        repeat (3) tick();
        chk("en.valid", 32'(ev_valid), 0);
        chk("en.count", 32'(fifo_count), 0);
        chk("en.drop",  32'(drop_cnt),   0);
        en = 1'b1; spike_in = 5'b00000;

        // 6c. reset while holding 4 entries
        ev_ready = 1'b0; spike_in = 5'b00001;
        repeat (5) tick();
        spike_in = 5'b00000;
        chk("mid.count4", 32'(fifo_count), 4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid.count0", 32'(fifo_count), 0);
        chk_head("mid.rst", 1'b0, 3'd0, 8'd0);
        tick(); tick();
        chk("mid.nopend", 32'(fifo_count), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
